// File: rtl/safe_control_param.sv
// safe_control_param: parametrised keypad safe controller with a wrong-code
// attempt limit and a timed lockout.
module safe_control_param #(
  parameter int CODE_LEN       = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [3:0]                       invalue,
  output logic                             lock,
  output logic                             green,
  output logic                             blue,
  output logic                             red,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt
);
  localparam int IW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int CW = $clog2(LOCKOUT_CYCLES);
  localparam int RW = CODE_LEN * 4;

  typedef enum logic [1:0] {SET_ENTER, SET_CONFIRM, ARMED, LOCKOUT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   row0_q, row0_d, row1_q, row1_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            lock_q, lock_d, green_q, green_d, blue_q, blue_d, red_q, red_d;
  logic            is_digit, is_hash, is_star, full, match;

  assign is_digit = invalue < 4'd10;
  assign is_hash  = invalue == 4'd10;
  assign is_star  = invalue == 4'd11;
  assign full     = idx_q == IW'(CODE_LEN);
  assign match    = row0_q == row1_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row0_d  = row0_q;
    row1_d  = row1_q;
    fail_d  = fail_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    green_d = green_q;
    blue_d  = blue_q;
    red_d   = red_q;
    if (state_q == LOCKOUT) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        state_d = ARMED;
        red_d   = 1'b0;
        blue_d  = 1'b1;
        fail_d  = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    end else if (is_digit && !full) begin
      idx_d = idx_q + IW'(1);
      for (int i = 0; i < CODE_LEN; i++)
        if (idx_q == IW'(i)) begin
          if (state_q == SET_ENTER) row0_d[i*4 +: 4] = invalue;
          else row1_d[i*4 +: 4] = invalue;
        end
    end else if (is_star) begin
      idx_d   = '0;
      state_d = (state_q == SET_CONFIRM) ? SET_ENTER : state_q;
    end else if (is_hash && full) begin
      idx_d = '0;
      if (state_q == SET_ENTER) begin
        state_d = SET_CONFIRM;
      end else if (state_q == SET_CONFIRM) begin
        state_d = match ? ARMED : SET_ENTER;
        lock_d  = match;
        green_d = !match;
        blue_d  = match;
      end else if (match) begin
        state_d = SET_ENTER;
        lock_d  = 1'b0;
        green_d = 1'b1;
        blue_d  = 1'b0;
        fail_d  = '0;
      end else begin
        fail_d = (fail_q == FW'(MAX_TRIES)) ? fail_q : fail_q + FW'(1);
        if (fail_q + FW'(1) == FW'(MAX_TRIES)) begin
          state_d = LOCKOUT;
          red_d   = 1'b1;
          blue_d  = 1'b0;
          cnt_d   = CW'(LOCKOUT_CYCLES - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SET_ENTER;
      idx_q   <= '0;
      row0_q  <= '0;
      row1_q  <= '0;
      fail_q  <= '0;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      green_q <= 1'b1;
      blue_q  <= 1'b0;
      red_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row0_q  <= row0_d;
      row1_q  <= row1_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      red_q   <= red_d;
    end
  end

  assign lock     = lock_q;
  assign green    = green_q;
  assign blue     = blue_q;
  assign red      = red_q;
  assign fail_cnt = fail_q;
endmodule

// File: tb/tb_safe_control_param.sv
// tb_safe_control_param: directed scoreboard bench for the keypad safe controller.
module tb_safe_control_param;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] invalue = 4'd13;
  logic       lock, green, blue, red;
  logic [1:0] fail_cnt;
  int         total = 0;
  int         bad = 0;
  int         red_total = 0;
  int         red_start;

  localparam logic [5:0] OPEN  = 6'b010000;
  localparam logic [5:0] ARM0  = 6'b101000;
  localparam logic [5:0] ARM1  = 6'b101001;
  localparam logic [5:0] ARM2  = 6'b101010;
  localparam logic [5:0] LOCK3 = 6'b100111;
  localparam logic [3:0] H = 4'd10;
  localparam logic [3:0] S = 4'd11;

  typedef struct {
    string      tag;
    logic [5:0] v;
  } exp_t;
  exp_t sb[$];

  safe_control_param #(.CODE_LEN(4), .MAX_TRIES(3), .LOCKOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .invalue(invalue),
    .lock(lock), .green(green), .blue(blue), .red(red), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (red === 1'b1) red_total <= red_total + 1;

  task automatic cmp(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_sb();
    exp_t e;
    logic [5:0] obs;
    obs = {lock, green, blue, red, fail_cnt};
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic press(input logic [3:0] k);
    invalue = k;
    @(negedge clk);
    invalue = 4'd13;
    @(negedge clk);
  endtask

  task automatic pk(input logic [3:0] k, input string tag, input logic [5:0] v, input bit gap = 1);
    sb.push_back('{tag, v});
    invalue = k;
    @(negedge clk);
    invalue = 4'd13;
    check_sb();
    if (gap) @(negedge clk);
  endtask

  task automatic digits(input logic [3:0] a, b, c, d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic arm1234();
    digits(1, 2, 3, 4); pk(H, "arm_first_hash", OPEN);
    digits(1, 2, 3, 4); pk(H, "arm_confirm", ARM0);
  endtask

  initial begin
    #12;
    sb.push_back('{"reset_state", OPEN});
    check_sb();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    // set code
    arm1234();
    // unlock with stray digit and clear
    press(9); press(S);
    digits(1, 2, 3, 4); pk(H, "unlock", OPEN);
    // confirm mismatch
    digits(1, 2, 3, 4); pk(H, "mm_first_hash", OPEN);
    digits(1, 2, 3, 5); pk(H, "confirm_mismatch", OPEN);
    // short # ignored, 5th digit ignored
    press(5); press(6); press(7);
    pk(H, "short_hash", OPEN);
    press(8); press(9);
    pk(H, "full_hash", OPEN);
    digits(5, 6, 7, 8); pk(H, "arm5678", ARM0);
    digits(5, 6, 7, 9); pk(H, "wrong5679", ARM1);
    digits(5, 6, 7, 8); pk(H, "unlock5678", OPEN);
    // fail counter clear
    arm1234();
    digits(0, 0, 0, 0); pk(H, "clr_wrong1", ARM1);
    digits(0, 0, 0, 0); pk(H, "clr_wrong2", ARM2);
    digits(1, 2, 3, 4); pk(H, "clr_unlock", OPEN);
    arm1234();
    digits(0, 0, 0, 0); pk(H, "one_wrong", ARM1);
    digits(1, 2, 3, 4); pk(H, "unlock_after_one", OPEN);
    // lockout
    arm1234();
    digits(0, 0, 0, 0); pk(H, "lo_wrong1", ARM1);
    digits(0, 0, 0, 0); pk(H, "lo_wrong2", ARM2);
    red_start = red_total;
    digits(0, 0, 0, 0); pk(H, "lo_enter", LOCK3);
    pk(1, "lo_key1", LOCK3, 0);
    pk(2, "lo_key2", LOCK3, 0);
    pk(3, "lo_key3", LOCK3, 0);
    pk(4, "lo_key4", LOCK3, 0);
    pk(H, "lo_hash", LOCK3, 0);
    for (int i = 0; i < 20 && red === 1'b1; i++) @(negedge clk);
    cmp("red_cycles", red_total - red_start, 8);
    sb.push_back('{"lo_exit", ARM0});
    check_sb();
    digits(1, 2, 3, 4); pk(H, "post_lo_unlock", OPEN);
    // async reset mid-lockout
    arm1234();
    digits(0, 0, 0, 0); pk(H, "rs_wrong1", ARM1);
    digits(0, 0, 0, 0); pk(H, "rs_wrong2", ARM2);
    digits(0, 0, 0, 0); pk(H, "rs_lock", LOCK3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    sb.push_back('{"async_reset", OPEN});
    check_sb();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    digits(1, 2, 3, 4); pk(H, "new_set_hash", OPEN);
    digits(1, 2, 3, 4); pk(H, "new_set_arm", ARM0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/safe_control_param.md
Name: safe_control_param

Overview:
Parametrised keypad safe controller, next generation of the team's 4-digit safe controller. It supports a configurable code length and an attempt limit. After MAX_TRIES consecutive wrong unlock codes it enters a timed lockout. It sits between the keypad decoder (one-cycle key strobes) and the lock actuator / RGB status LED.

Parameters:
CODE_LEN, 4, number of digits in a code (1..8); code storage is CODE_LEN x 4 bits per row.
MAX_TRIES, 3, consecutive wrong unlock attempts that trigger lockout (1..15).
LOCKOUT_CYCLES, 1000, lockout duration in clk cycles (>=2).

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  asynchronous, active-low reset.
invalue  in  4  key code: 0-9 digit, 10 = # (enter), 11 = * (clear), 13 = no key; 12/14/15 ignored.
lock  out  1  0 = open, 1 = closed.
green  out  1  open indicator.
blue  out  1  locked/armed indicator.
red  out  1  lockout indicator.
fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive wrong unlock attempts.

Behaviour:
- Reset (rst=0, async): state=SET_ENTER, lock=0, green=1, blue=0, red=0, fail_cnt=0, digit index idx=0, both code rows cleared to 0, lockout counter=0.
- Key event: a cycle with invalue in {0..11}. One event per cycle. All outputs are registered and update on the same edge the key is sampled (1-cycle latency).
- Digit: written to the active row at idx, then idx++. Ignored when idx==CODE_LEN.
- *: idx<=0. Row contents are unchanged.
- # with idx<CODE_LEN: ignored.
- States:
  - SET_ENTER: digits go to row 0 (new code). # with a full buffer -> SET_CONFIRM, idx<=0.
  - SET_CONFIRM: digits go to row 1. * also returns to SET_ENTER with idx<=0. # with a full buffer compares all CODE_LEN digits:
    - match -> ARMED, lock=1, green=0, blue=1, idx<=0.
    - mismatch -> SET_ENTER, idx<=0. fail_cnt is not changed.
  - ARMED: digits go to row 1 (attempt). # with a full buffer compares:
    - match -> SET_ENTER, lock=0, green=1, blue=0, fail_cnt<=0, idx<=0.
    - mismatch -> fail_cnt++, idx<=0. If fail_cnt+1==MAX_TRIES -> LOCKOUT, red=1, blue=0, lockout counter<=LOCKOUT_CYCLES-1.
  - LOCKOUT: all keys, including *, are ignored. lock stays 1. The counter decrements every cycle. On the edge where the counter is 0: go to ARMED, red=0, blue=1, fail_cnt<=0, idx<=0. red is high for exactly LOCKOUT_CYCLES cycles.
- Stored code (row 0) is preserved through ARMED and LOCKOUT. Only reset or a new SET sequence changes it.
- Outputs are one-hot in steady state: exactly one of green/blue/red is high.
- Reset mid-operation (any state, including LOCKOUT): immediate return to reset values. The stored code is lost and the safe opens. This is the intended service behaviour.
- fail_cnt saturates at MAX_TRIES and never wraps.
- No-key (13) and codes 12/14/15 hold all state, except the LOCKOUT counter.

Test Plan:
Bench uses CODE_LEN=4, MAX_TRIES=3, LOCKOUT_CYCLES=8. Keys are one-cycle strobes separated by invalue=13.
- Set code: keys 1,2,3,4,#,1,2,3,4,# -> lock=1, blue=1, green=0 on the edge sampling the second #; fail_cnt=0.
- Confirm mismatch and ignored keys: keys 1,2,3,4,#,1,2,3,5,# -> stays unlocked (lock=0, green=1), back in SET_ENTER. A # after only 3 digits changes nothing. A 5th digit is ignored.
- Unlock: from armed with code 1234, keys 9,*,1,2,3,4,# -> lock=0, green=1, blue=0, fail_cnt=0.
- Lockout: armed with 1234; enter 0000# three times -> fail_cnt 1, 2, then red=1 and blue=0 on the third #. Keys 1,2,3,4,# during lockout are ignored. red is high for exactly 8 cycles, then blue=1, fail_cnt=0, lock=1. A subsequent 1234# unlocks.
- Fail counter clear: two wrong codes then 1234# -> unlock, fail_cnt=0. Re-arm, then one wrong code -> fail_cnt=1, no lockout.
- Async reset: assert rst=0 mid-lockout between clock edges -> outputs immediately lock=0, green=1, blue=0, red=0, fail_cnt=0. Code 1234# in the new SET_ENTER is treated as new-code entry.
